// File: rtl/alu_op_sequencer_pkg.sv
// alu_op_sequencer_pkg: instruction layout, ALU opcodes and sequencer states
package alu_op_sequencer_pkg;
   localparam int INSTR_W  = 9;
   localparam int A_LSB    = 0;
   localparam int B_LSB    = 2;
   localparam int CTRL_LSB = 4;
   localparam int REG_LSB  = 6;
   localparam int WR_BIT   = 8;
   typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11} alu_op_e;
   typedef enum logic [2:0] {S_IDLE, S_SYNC, S_ISSUE, S_FINISH, S_FAULT} seq_state_e;
endpackage

// File: rtl/alu_op_sequencer_prog_mem.sv
// seq_prog_mem: DEPTH x INSTR_W program store, synchronous write, asynchronous read, no reset
module seq_prog_mem
   import alu_op_sequencer_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               we,
   input  logic [AW-1:0]      waddr,
   input  logic [INSTR_W-1:0] wdata,
   input  logic [AW-1:0]      raddr,
   output logic [INSTR_W-1:0] rdata
);
   logic [INSTR_W-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues a stored ALU program one instruction per ALU loop, aligned to alu_done
module alu_op_sequencer
   import alu_op_sequencer_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int AW      = $clog2(DEPTH),
   parameter int TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [8:0]    prog_data,
   input  logic [AW:0]   prog_len,
   input  logic          start,
   output logic          busy,
   output logic          seq_done,
   output logic [1:0]    err,
   output logic [AW-1:0] pc,
   output logic [1:0]    alu_a,
   output logic [1:0]    alu_b,
   output logic [1:0]    alu_ctrl,
   output logic [1:0]    alu_reg_addr,
   output logic          alu_reg_write,
   input  logic [3:0]    alu_y,
   input  logic          alu_c,
   input  logic          alu_done,
   output logic [3:0]    last_y,
   output logic [AW:0]   carry_cnt
);
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);
   localparam logic [AW:0] CNT_MAX = '1;
   seq_state_e state, state_d;
   logic [AW:0] len, len_d, carry_cnt_d;
   logic [WW-1:0] wait_cnt, wait_d;
   logic [AW-1:0] pc_d, raddr;
   logic [INSTR_W-1:0] ins, alu_out, alu_out_d;
   logic [1:0] err_d;
   logic [3:0] last_y_d;
   logic last;
   seq_prog_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
      .clk(clk), .we(prog_we && !busy), .waddr(prog_addr), .wdata(prog_data),
      .raddr(raddr), .rdata(ins)
   );
   // SYNC fetches entry 0; ISSUE prefetches the entry after the one on the bus
   assign raddr = state == S_ISSUE ? pc + AW'(1) : '0;
   assign last = {1'b0, pc} == len - (AW+1)'(1);
   assign alu_a = alu_out[A_LSB +: 2];
   assign alu_b = alu_out[B_LSB +: 2];
   assign alu_ctrl = alu_out[CTRL_LSB +: 2];
   assign alu_reg_addr = alu_out[REG_LSB +: 2];
   assign alu_reg_write = alu_out[WR_BIT];
   always_comb begin
      state_d = state;
      pc_d = pc;
      len_d = len;
      alu_out_d = alu_out;
      err_d = err;
      last_y_d = last_y;
      carry_cnt_d = carry_cnt;
      case (state)
         S_IDLE: if (start) begin
            len_d = prog_len > LEN_MAX ? LEN_MAX : prog_len;
            pc_d = '0;
            err_d = '0;
            carry_cnt_d = '0;
            state_d = prog_len == '0 ? S_FINISH : S_SYNC;
         end
         S_SYNC, S_ISSUE: if (alu_done) begin
            if (state == S_ISSUE) begin
               last_y_d = alu_y;
               carry_cnt_d = alu_c && carry_cnt != CNT_MAX ? carry_cnt + (AW+1)'(1) : carry_cnt;
               err_d[0] = err[0] | (alu_c && alu_ctrl == OP_DIV);
            end
            state_d = state == S_ISSUE && last ? S_FINISH : S_ISSUE;
            pc_d = state == S_ISSUE && !last ? pc + AW'(1) : pc;
            alu_out_d = state_d == S_FINISH ? '0 : ins;
         end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
            state_d = S_FAULT;
            err_d[1] = 1'b1;
            alu_out_d = '0;
         end
         default: state_d = S_IDLE;
      endcase
      wait_d = state_d != state || alu_done ? '0 : wait_cnt + WW'(1);
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state <= S_IDLE;
         pc <= '0;
         len <= '0;
         wait_cnt <= '0;
         alu_out <= '0;
         err <= '0;
         last_y <= '0;
         carry_cnt <= '0;
         busy <= 1'b0;
         seq_done <= 1'b0;
      end else begin
         state <= state_d;
         pc <= pc_d;
         len <= len_d;
         wait_cnt <= wait_d;
         alu_out <= alu_out_d;
         err <= err_d;
         last_y <= last_y_d;
         carry_cnt <= carry_cnt_d;
         busy <= state_d inside {S_SYNC, S_ISSUE};
         seq_done <= state_d inside {S_FINISH, S_FAULT};
      end
endmodule
